// File: rtl/ltl_symbol_pkg.sv
// Shared types and defaults for the runtime-verification symbol feeder.
package ltl_symbol_pkg;

  typedef logic [7:0] symbol_t;

  typedef enum logic [1:0] {
    S_RST    = 2'd0,
    S_ARM    = 2'd1,
    S_STREAM = 2'd2
  } tx_state_e;

  localparam int DEPTH_DEF          = 8;
  localparam int MON_RST_CYCLES_DEF = 2;

endpackage

// File: rtl/ltl_symbol_fifo.sv
// Synchronous symbol FIFO with flush; pointers wrap naturally on a power-of-two depth.
module ltl_symbol_fifo
  import ltl_symbol_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush,
  input  logic                         push,
  input  logic                         pop,
  input  logic [7:0]                   wdata,
  output logic [7:0]                   rdata,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  symbol_t        mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic           do_push;
  logic           do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; only the pointers and count define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/ltl_symbol_tx.sv
// Symbol feeder for the automata clusters: buffers predicate vectors and sequences cluster reset/start.
// Optional counters enabled by defining LTL_SYMBOL_TX_STATS_EN.
module ltl_symbol_tx
  import ltl_symbol_pkg::*;
#(
  parameter int DEPTH          = DEPTH_DEF,
  parameter int MON_RST_CYCLES = MON_RST_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_pred,
  input  logic        restart,
  input  logic        mon_hold,
  output logic [7:0]  mon_symbols,
  output logic        mon_run,
  output logic        mon_reset,
  output logic [31:0] stat_sent,
  output logic [31:0] stat_full
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int RW = $clog2(MON_RST_CYCLES + 1);

  localparam logic [1:0]    ST_RST    = S_RST;
  localparam logic [1:0]    ST_ARM    = S_ARM;
  localparam logic [1:0]    ST_STREAM = S_STREAM;
  localparam logic [RW-1:0] RST_LAST  = RW'(MON_RST_CYCLES - 1);

  logic [1:0]    state;
  logic [RW-1:0] rst_cnt;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  logic [7:0]    fifo_head;
  logic          active;
  logic          push;
  logic          pop;

  assign active   = (state == ST_ARM) || (state == ST_STREAM);
  assign in_ready = !reset && !restart && !fifo_full && (state != ST_RST);
  assign push     = in_valid && in_ready;
  // A restart cycle never issues, so nothing follows the flush on mon_run.
  assign pop      = active && !reset && !restart && !mon_hold && !fifo_empty;

  ltl_symbol_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (restart),
    .push  (push),
    .pop   (pop),
    .wdata (in_pred),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (reset || restart) begin
      state       <= ST_RST;
      rst_cnt     <= '0;
      mon_reset   <= 1'b1;
      mon_run     <= 1'b0;
      mon_symbols <= 8'h00;
    end else begin
      mon_run <= pop;
      if (pop) begin
        mon_symbols <= fifo_head;
        mon_reset   <= 1'b0;
      end
      case (state)
        ST_RST: begin
          if (rst_cnt == RST_LAST) state <= ST_ARM;
          else                     rst_cnt <= rst_cnt + 1'b1;
        end
        ST_ARM: begin
          if (fifo_count != '0 && !mon_hold) state <= ST_STREAM;
        end
        default: state <= ST_STREAM;
      endcase
    end
  end

`ifdef LTL_SYMBOL_TX_STATS_EN
  logic [31:0] sent_cnt;
  logic [31:0] full_cnt;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // Counters survive restart; only the system reset clears them.
  always_ff @(posedge clk) begin
    if (reset) begin
      sent_cnt <= '0;
      full_cnt <= '0;
    end else begin
      if (mon_run)               sent_cnt <= sat_inc(sent_cnt);
      if (in_valid && fifo_full) full_cnt <= sat_inc(full_cnt);
    end
  end

  assign stat_sent = sent_cnt;
  assign stat_full = full_cnt;
`else
  assign stat_sent = '0;
  assign stat_full = '0;
`endif

endmodule

// File: tb/tb_ltl_symbol_tx.sv
// Directed bench for ltl_symbol_tx: one DEPTH=8 instance and one DEPTH=4 instance for the wrap test.
module tb_ltl_symbol_tx;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset    = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  in_pred  = 8'h00;
  logic        restart  = 1'b0;
  logic        mon_hold = 1'b0;
  logic        in_ready;
  logic [7:0]  mon_symbols;
  logic        mon_run;
  logic        mon_reset;
  logic [31:0] stat_sent;
  logic [31:0] stat_full;

  logic        in_valid4 = 1'b0;
  logic [7:0]  in_pred4  = 8'h00;
  logic        restart4  = 1'b0;
  logic        mon_hold4 = 1'b0;
  logic        in_ready4;
  logic [7:0]  mon_symbols4;
  logic        mon_run4;
  logic        mon_reset4;
  logic [31:0] stat_sent4;
  logic [31:0] stat_full4;

  int passed = 0;
  int total  = 0;
  int failed = 0;

  ltl_symbol_tx #(.DEPTH(8), .MON_RST_CYCLES(2)) u_dut8 (
    .clk (clk), .reset (reset), .in_valid (in_valid), .in_ready (in_ready),
    .in_pred (in_pred), .restart (restart), .mon_hold (mon_hold),
    .mon_symbols (mon_symbols), .mon_run (mon_run), .mon_reset (mon_reset),
    .stat_sent (stat_sent), .stat_full (stat_full)
  );

  ltl_symbol_tx #(.DEPTH(4), .MON_RST_CYCLES(2)) u_dut4 (
    .clk (clk), .reset (reset), .in_valid (in_valid4), .in_ready (in_ready4),
    .in_pred (in_pred4), .restart (restart4), .mon_hold (mon_hold4),
    .mon_symbols (mon_symbols4), .mon_run (mon_run4), .mon_reset (mon_reset4),
    .stat_sent (stat_sent4), .stat_full (stat_full4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state
    repeat (3) tick();
    chk("rst_in_ready",  in_ready, 0);
    chk("rst_mon_reset", mon_reset, 1);
    chk("rst_mon_run",   mon_run, 0);
    chk("rst_symbols",   mon_symbols, 8'h00);
    chk("rst_stat_sent", stat_sent, 0);
    chk("rst_stat_full", stat_full, 0);
    chk("rst_ready4",    in_ready4, 0);

    // First symbol after reset: 8'h41 offered from the first deasserted cycle
    reset = 1'b0; in_valid = 1'b1; in_pred = 8'h41;
    #1;
    chk("first_ready_rst0", in_ready, 0);
    tick();
    chk("first_ready_rst1", in_ready, 0);
    chk("first_monrst_rst1", mon_reset, 1);
    tick();
    chk("first_ready_arm", in_ready, 1);
    chk("first_monrst_arm", mon_reset, 1);
    tick();
    in_valid = 1'b0;
    chk("first_run_push", mon_run, 0);
    chk("first_monrst_push", mon_reset, 1);
    tick();
    chk("first_run", mon_run, 1);
    chk("first_monrst_fall", mon_reset, 0);
    chk("first_sym", mon_symbols, 8'h41);
    tick();
    chk("first_run_end", mon_run, 0);
    chk("first_sym_hold", mon_symbols, 8'h41);

    // Burst of 8 under hold, then 3 cycles of in_valid while full
    mon_hold = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_pred = 8'(i);
      tick();
    end
    in_pred = 8'hEE;
    chk("burst_ready_full", in_ready, 0);
    chk("burst_count", u_dut8.u_fifo.count, 8);
    repeat (3) tick();
    in_valid = 1'b0;
    chk("burst_hold_run", mon_run, 0);
    chk("burst_count_kept", u_dut8.u_fifo.count, 8);
    mon_hold = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("drain_run", mon_run, 1);
      chk("drain_sym", mon_symbols, 32'(i));
    end
    tick();
    chk("drain_run_end", mon_run, 0);
    chk("drain_sym_hold", mon_symbols, 8'h07);
`ifdef LTL_SYMBOL_TX_STATS_EN
    chk("stat_sent_a", stat_sent, 9);
    chk("stat_full_a", stat_full, 3);
`else
    chk("stat_sent_a", stat_sent, 0);
    chk("stat_full_a", stat_full, 0);
`endif

    // Restart with 3 entries buffered
    mon_hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_pred = 8'hA1 + 8'(i);
      tick();
    end
    in_valid = 1'b0;
    chk("rs_count_pre", u_dut8.u_fifo.count, 3);
    restart = 1'b1; mon_hold = 1'b0;
    tick();
    restart = 1'b0;
    chk("rs_run0", mon_run, 0);
    chk("rs_monrst0", mon_reset, 1);
    chk("rs_ready0", in_ready, 0);
    chk("rs_count0", u_dut8.u_fifo.count, 0);
    chk("rs_sym0", mon_symbols, 8'h00);
    tick();
    chk("rs_run1", mon_run, 0);
    chk("rs_monrst1", mon_reset, 1);
    chk("rs_ready1", in_ready, 0);
    tick();
    chk("rs_run2", mon_run, 0);
    chk("rs_monrst2", mon_reset, 1);
    chk("rs_ready_arm", in_ready, 1);
`ifdef LTL_SYMBOL_TX_STATS_EN
    chk("stat_sent_rs", stat_sent, 9);
    chk("stat_full_rs", stat_full, 3);
`else
    chk("stat_sent_rs", stat_sent, 0);
    chk("stat_full_rs", stat_full, 0);
`endif
    in_valid = 1'b1; in_pred = 8'hA0;
    tick();
    in_valid = 1'b0;
    chk("rs_run_push", mon_run, 0);
    tick();
    chk("rs_first_run", mon_run, 1);
    chk("rs_first_sym", mon_symbols, 8'hA0);
    chk("rs_first_monrst", mon_reset, 0);
    tick();
    chk("rs_run_end", mon_run, 0);

    // in_valid coincident with restart is refused; re-offered vector lands after S_RST
    in_valid = 1'b1; in_pred = 8'h5C; restart = 1'b1;
    #1;
    chk("co_ready", in_ready, 0);
    tick();
    restart = 1'b0;
    chk("co_count0", u_dut8.u_fifo.count, 0);
    chk("co_ready0", in_ready, 0);
    tick();
    chk("co_ready1", in_ready, 0);
    tick();
    chk("co_ready_arm", in_ready, 1);
    tick();
    in_valid = 1'b0;
    chk("co_count1", u_dut8.u_fifo.count, 1);
    chk("co_run_push", mon_run, 0);
    tick();
    chk("co_run", mon_run, 1);
    chk("co_sym", mon_symbols, 8'h5C);
    chk("co_monrst", mon_reset, 0);
    tick();
    chk("co_run_end", mon_run, 0);
`ifdef LTL_SYMBOL_TX_STATS_EN
    chk("stat_sent_end", stat_sent, 11);
    chk("stat_full_end", stat_full, 3);
`else
    chk("stat_sent_end", stat_sent, 0);
    chk("stat_full_end", stat_full, 0);
`endif

    // DEPTH=4: steady push+pop at occupancy 2 for 20 cycles, pointers wrap
    mon_hold4 = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_valid4 = 1'b1; in_pred4 = 8'h10 + 8'(i);
      tick();
    end
    chk("w_count_pre", u_dut4.u_fifo.count, 2);
    chk("w_run_pre", mon_run4, 0);
    mon_hold4 = 1'b0;
    for (int i = 0; i < 20; i++) begin
      in_pred4 = 8'h12 + 8'(i);
      tick();
      chk("w_run", mon_run4, 1);
      chk("w_sym", mon_symbols4, 32'h10 + 32'(i));
      chk("w_count", u_dut4.u_fifo.count, 2);
    end
    in_valid4 = 1'b0;
    tick();
    chk("w_tail_run0", mon_run4, 1);
    chk("w_tail_sym0", mon_symbols4, 8'h24);
    tick();
    chk("w_tail_run1", mon_run4, 1);
    chk("w_tail_sym1", mon_symbols4, 8'h25);
    tick();
    chk("w_run_end", mon_run4, 0);
    chk("w_count_end", u_dut4.u_fifo.count, 0);
`ifdef LTL_SYMBOL_TX_STATS_EN
    chk("w_stat_sent", stat_sent4, 22);
    chk("w_stat_full", stat_full4, 0);
`else
    chk("w_stat_sent", stat_sent4, 0);
    chk("w_stat_full", stat_full4, 0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
